muldiv_unit: RTL and testbench

Iterative MIPS multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file: it consumes the two read-port operands (rs, rt) for MULT/MULTU/DIV/DIVU. Its HI/LO results feed the writeback mux for MFHI/MFLO. `busy` is the stall request to the control unit.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;   // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] q;      // multiplier / low product bits, or dividend / quotient
  logic [WIDTH:0]   acc;    // high product bits, or partial remainder
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    sgn      = ~op[0];
    mag_a    = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    mag_b    = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    addend   = q[0] ? opnd : '0;
    mul_sum  = acc + {1'b0, addend};
    div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = (div_sh >= {1'b0, opnd});
    prod     = {acc[WIDTH-1:0], q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -q : q;
    rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opnd   <= '0;
      q      <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= '0;
            acc    <= '0;
            is_div <= op[1];
            if (!op[1]) begin
              opnd  <= mag_a;
              q     <= mag_b;
              neg_q <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_r <= 1'b0;
            end else if (rt_data == '0) begin
              // Dividing the raw dividend by zero yields all-ones quotient and
              // leaves the dividend as remainder, so no sign fix-up is wanted.
              opnd  <= '0;
              q     <= rs_data;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              opnd  <= mag_b;
              q     <= mag_a;
              neg_q <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_r <= sgn & rs_data[WIDTH-1];
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
          if (!is_div) begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end else if (div_ge) begin
            acc <= div_diff;
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            acc <= div_sh;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from MIPS arithmetic rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] p;
    logic [31:0] qq, rr;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'(sa * sb);
        return p;
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        qq = 32'(ia / ib);
        rr = 32'(ia % ib);
        return {rr, qq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Presents one start at a negedge; returns at the negedge after the accepting edge
  // with the operands scrambled so late sampling would be visible.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && n < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] exp [6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                             64'hFFFF_FFFF_FFFF_FFFD, {32'd2, 32'd14},
                             {32'd100, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
    int n; bit bok;
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(n, bok);
      vectors++;
      if (n !== 33 || !bok || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: done after %0d edges busy_ok=%b busy=%b, required 33/1/0", i, n, bok, busy);
      end
      vectors++;
      if ({hi, lo} !== exp[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: hi:lo=%h:%h, required %h", i, hi, lo, exp[i]);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse[%0d]: done=%b one cycle later, required 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] o; logic [31:0] a, b; logic [63:0] e;
    int n; bit bok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      e = model(o, a, b);
      launch(o, a, b);
      wait_done(n, bok);
      vectors++;
      if (n !== 33 || {hi, lo} !== e) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: edges=%0d hi:lo=%h:%h, required 33 %h", i, o, a, b, n, hi, lo, e);
      end
    end
  endtask

  task automatic test_ignore();
    logic [31:0] a, b, hsave; logic [63:0] e;
    int n; bit bok;
    a = $urandom; b = $urandom;
    e = model(2'b00, a, b);
    launch(2'b00, a, b);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'h55; rt_data = 32'h66; mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(n, bok);
    vectors++;
    if (n !== 28 || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL ignore_busy: edges=%0d hi:lo=%h:%h, required 28 %h", n, hi, lo, e);
    end
    hsave = e[63:32];
    mtlo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    vectors++;
    if (lo !== 32'hABCD || hi !== hsave) begin
      miscompares++;
      $display("FAIL mtlo_after_done: hi=%h lo=%h, required hi=%h lo=0000abcd", hi, lo, hsave);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    vectors++;
    if (hi !== wdata || lo !== wdata) begin
      miscompares++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required %h", hi, lo, wdata);
    end
    hsave = wdata;
    wdata = $urandom;
    repeat (5) @(negedge clk);
    vectors++;
    if (hi !== hsave || lo !== hsave) begin
      miscompares++;
      $display("FAIL idle_hold: hi=%h lo=%h, required %h", hi, lo, hsave);
    end
  endtask

  task automatic test_abort();
    logic [31:0] a, b; logic [63:0] e;
    int n; bit bok; bit saw_done;
    launch(2'b10, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL abort_no_done: done=1 after aborted op, required no pulse");
    end
    a = $urandom; b = $urandom_range(1, 1000);
    e = model(2'b11, a, b);
    launch(2'b11, a, b);
    wait_done(n, bok);
    vectors++;
    if (n !== 33 || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL abort_restart: edges=%0d hi:lo=%h:%h, required 33 %h", n, hi, lo, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2; logic [63:0] e1, e2;
    int n; bit bok;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 50);
    e1 = model(2'b01, a1, b1);
    e2 = model(2'b10, a2, b2);
    launch(2'b01, a1, b1);
    wait_done(n, bok);
    vectors++;
    if ({hi, lo} !== e1) begin
      miscompares++;
      $display("FAIL b2b_first: hi:lo=%h:%h, required %h", hi, lo, e1);
    end
    launch(2'b10, a2, b2);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_done(n, bok);
    vectors++;
    if (n !== 33 || !bok || {hi, lo} !== e2) begin
      miscompares++;
      $display("FAIL b2b_second: edges=%0d busy_ok=%b hi:lo=%h:%h, required 33 1 %h", n, bok, hi, lo, e2);
    end
    @(negedge clk);
    e1 = model(2'b00, a1, b1);
    mthi = 1'b1; wdata = 32'h5A5A_5A5A;
    launch(2'b00, a1, b1);
    mthi = 1'b0;
    wait_done(n, bok);
    vectors++;
    if (n !== 33 || {hi, lo} !== e1) begin
      miscompares++;
      $display("FAIL start_beats_mthi: edges=%0d hi:lo=%h:%h, required 33 %h", n, hi, lo, e1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
